// File: rtl/mem_resp.sv
// 128 x 64-bit single-port memory responder: req/ack handshake, 1-cycle reads, zero-fill after reset.
// Optional write protection of the instruction region is enabled by defining MEM_RESP_WPROT_EN.
module mem_resp #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 128,
  parameter int DATA_OFFSET = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ack,
  output logic              busy,
  output logic              err
);

`ifdef MEM_RESP_WPROT_EN
  localparam logic WPROT_EN = 1'b1;
`else
  localparam logic WPROT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(DATA_OFFSET);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              ack_reg, err_reg;
  logic              accept, wr_blocked, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr;
    wr_data    = data_in;
    wr_blocked = WPROT_EN && mode && (addr < DATA_BASE);
    case (state_reg)
      CLEAR: begin
        // The clear walk owns the single write port until the last word is zeroed.
        wr_en    = 1'b1;
        wr_addr  = ptr_reg;
        wr_data  = '0;
        ptr_next = ptr_reg + ADDR_W'(1);
        if (ptr_reg == LAST_ADDR) begin
          state_next = READY;
        end
      end
      READY: begin
        accept = req;
        wr_en  = req && mode && !wr_blocked;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      ptr_reg      <= '0;
      data_out_reg <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      ack_reg   <= accept;
      err_reg   <= accept && wr_blocked;
      if (accept && !mode) begin
        data_out_reg <= mem[addr];
      end
    end
  end

  // Array kept free of reset so it maps to block RAM; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign data_out = data_out_reg;
  assign ack      = ack_reg;
  assign err      = err_reg;
  assign busy     = (state_reg == CLEAR);

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: randomized traffic against a word-array reference model.
module tb_mem_resp;

`ifdef MEM_RESP_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        mode = 1'b0;
  logic [6:0]  addr = '0;
  logic [63:0] data_in = '0;
  logic [63:0] data_out;
  logic        ack, busy, err;

  int checks = 0;
  int failures = 0;

  // Reference model: contents, remaining clear cycles, expected outputs after each edge.
  logic [63:0] mdl [128];
  int          clear_left = 128;
  logic        exp_ack = 1'b0;
  logic        exp_err = 1'b0;
  logic [63:0] exp_dout = '0;

  mem_resp dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model across the edge, return at the next negedge.
  task automatic drive(input logic r, input logic m, input logic [6:0] a, input logic [63:0] d);
    req = r; mode = m; addr = a; data_in = d;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (reset) begin
      clear_left = 128;
      for (int i = 0; i < 128; i++) mdl[i] = '0;
      exp_dout = '0;
    end else begin
      if (r && clear_left == 0) begin
        exp_ack = 1'b1;
        if (m) begin
          if (PROT && a < 7'd32) exp_err = 1'b1;
          else mdl[a] = d;
        end else begin
          exp_dout = mdl[a];
        end
      end
      if (clear_left > 0) clear_left--;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      checks++;
      if (ack !== 1'b0 || data_out !== 64'd0) begin
        failures++;
        $display("FAIL reset_idle ack=%0b data_out=%h required ack=0 data_out=0", ack, data_out);
      end
      n++;
      drive(0, 0, 0, 0);
    end
    checks++;
    if (n != 128) begin
      failures++;
      $display("FAIL reset_busy_len busy cycles=%0d required=128", n);
    end
    drive(1, 0, 7'd32, 0);
    req = 1'b0;
    checks++;
    if (ack !== 1'b1 || data_out !== 64'd0) begin
      failures++;
      $display("FAIL reset_first_read ack=%0b data_out=%h required ack=1 data_out=0", ack, data_out);
    end
  endtask

  task automatic test_raw();
    drive(1, 1, 7'd32, 64'h0000_0000_00AB_CDEF);
    checks++;
    if (ack !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL raw_write_ack ack=%0b err=%0b required ack=1 err=0", ack, err);
    end
    drive(1, 0, 7'd32, 0);
    req = 1'b0;
    checks++;
    if (ack !== 1'b1 || data_out !== 64'h0000_0000_00AB_CDEF) begin
      failures++;
      $display("FAIL raw_read ack=%0b data_out=%h required ack=1 data_out=abcdef", ack, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [10];
    int acks;
    void'($urandom(1964));
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      vals[i] = {40'd0, 24'($urandom)};
      drive(1, 1, 7'(32 + i), vals[i]);
      if (ack === 1'b1) acks++;
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 7'(32 + i), 0);
      if (ack === 1'b1) acks++;
      checks++;
      if (data_out !== vals[i]) begin
        failures++;
        $display("FAIL b2b_read addr=%0d data_out=%h required=%h", 32 + i, data_out, vals[i]);
      end
    end
    req = 1'b0;
    checks++;
    if (acks != 20) begin
      failures++;
      $display("FAIL b2b_acks count=%0d required=20", acks);
    end
  endtask

  task automatic test_req_during_clear();
    int n;
    reset = 1'b1;
    drive(1, 0, 7'd5, 0);
    reset = 1'b0;
    n = 0;
    while (ack !== 1'b1 && n < 200) begin
      drive(1, 0, 7'd5, 0);
      n++;
      checks++;
      if (ack !== exp_ack || busy !== (clear_left > 0)) begin
        failures++;
        $display("FAIL clear_hold cycle=%0d ack=%0b busy=%0b required ack=%0b busy=%0b",
                 n, ack, busy, exp_ack, clear_left > 0);
      end
    end
    req = 1'b0;
    checks++;
    if (n != 129 || data_out !== 64'd0) begin
      failures++;
      $display("FAIL clear_first_ack cycle=%0d data_out=%h required cycle=129 data_out=0", n, data_out);
    end
  endtask

  task automatic test_reset_midclear();
    int n;
    drive(1, 1, 7'd100, 64'hFFFF);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL midclear_prefill ack=%0b required=1", ack);
    end
    reset = 1'b1;
    drive(1, 1, 7'd100, 64'hFFFF);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) drive(0, 0, 0, 0);
    reset = 1'b1;
    drive(1, 1, 7'd100, 64'hFFFF);
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      drive(0, 0, 0, 0);
    end
    checks++;
    if (n != 128) begin
      failures++;
      $display("FAIL midclear_busy_len busy cycles=%0d required=128", n);
    end
    drive(1, 0, 7'd100, 0);
    req = 1'b0;
    checks++;
    if (ack !== 1'b1 || data_out !== 64'd0) begin
      failures++;
      $display("FAIL midclear_read ack=%0b data_out=%h required ack=1 data_out=0", ack, data_out);
    end
  endtask

  task automatic test_wprot();
    logic [63:0] want;
    drive(1, 1, 7'd3, 64'h1234);
    checks++;
    if (ack !== 1'b1 || err !== PROT) begin
      failures++;
      $display("FAIL wprot_write ack=%0b err=%0b required ack=1 err=%0b", ack, err, PROT);
    end
    drive(1, 0, 7'd3, 0);
    req = 1'b0;
    want = PROT ? 64'd0 : 64'h1234;
    checks++;
    if (ack !== 1'b1 || err !== 1'b0 || data_out !== want) begin
      failures++;
      $display("FAIL wprot_read ack=%0b err=%0b data_out=%h required ack=1 err=0 data_out=%h",
               ack, err, data_out, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 7'($urandom), {$urandom, $urandom});
      checks++;
      if (ack !== exp_ack || err !== exp_err || data_out !== exp_dout) begin
        failures++;
        $display("FAIL random op=%0d ack=%0b err=%0b data_out=%h required ack=%0b err=%0b data_out=%h",
                 i, ack, err, data_out, exp_ack, exp_err, exp_dout);
      end
    end
    req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_raw();
    test_back_to_back();
    test_wprot();
    test_random();
    test_req_during_clear();
    test_reset_midclear();
    drive(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
